// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32IM ALU issue stage: decode, operand registers, result capture and handshake
module alu_issue #(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        is_imm,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_r1,
    input  logic [31:0] alu_r2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_illegal
);

    localparam logic [3:0] OP_SLL  = 4'h0;
    localparam logic [3:0] OP_SRA  = 4'h1;
    localparam logic [3:0] OP_SRL  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_SLT  = 4'hB;
    localparam logic [3:0] OP_SLTU = 4'hC;

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);
    localparam logic [6:0] F7_M    = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  dec_op;
    logic        dec_sel;
    logic        dec_md;
    logic        dec_illegal;

    logic        sel_q;
    logic        md_q;
    logic [3:0]  cnt;

    logic        accept;
    logic        capture;
    logic [31:0] sel_result;

    always_comb begin
        dec_op      = OP_ADD;
        dec_sel     = 1'b0;
        dec_md      = 1'b0;
        dec_illegal = 1'b0;
        if (funct7 == F7_M) begin
            dec_md = 1'b1;
            case (funct3)
                3'b000: begin dec_op = OP_MUL; dec_sel = 1'b0; end
                3'b011: begin dec_op = OP_MUL; dec_sel = 1'b1; end
                3'b101: begin dec_op = OP_DIV; dec_sel = 1'b0; end
                3'b111: begin dec_op = OP_DIV; dec_sel = 1'b1; end
                default: dec_illegal = 1'b1;
            endcase
            // M-extension has no immediate forms
            if (is_imm) begin
                dec_illegal = 1'b1;
            end
        end else begin
            case (funct3)
                3'b000: dec_op = (funct7[5] && !is_imm) ? OP_SUB : OP_ADD;
                3'b001: dec_op = OP_SLL;
                3'b010: dec_op = OP_SLT;
                3'b011: dec_op = OP_SLTU;
                3'b100: dec_op = OP_XOR;
                3'b101: dec_op = funct7[5] ? OP_SRA : OP_SRL;
                3'b110: dec_op = OP_OR;
                default: dec_op = OP_AND;
            endcase
        end
    end

    assign accept  = in_valid && (state == IDLE);
    assign capture = (state == EXEC) && (!md_q || (cnt == 4'd0));

    // Divide by zero results are fixed here so the external divider's value is irrelevant
    always_comb begin
        sel_result = sel_q ? alu_r2 : alu_r1;
        if (md_q && (alu_op == OP_DIV) && (alu_b == 32'd0)) begin
            sel_result = sel_q ? alu_a : 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = dec_illegal ? HOLD : EXEC;
                end
            end
            EXEC: begin
                if (capture) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            alu_op      <= OP_ADD;
            sel_q       <= 1'b0;
            md_q        <= 1'b0;
            cnt         <= 4'd0;
            out_result  <= 32'd0;
            out_illegal <= 1'b0;
        end else begin
            if (accept) begin
                if (dec_illegal) begin
                    out_result  <= 32'd0;
                    out_illegal <= 1'b1;
                end else begin
                    alu_a  <= rs1_val;
                    alu_b  <= is_imm ? imm : rs2_val;
                    alu_op <= dec_op;
                    sel_q  <= dec_sel;
                    md_q   <= dec_md;
                    cnt    <= dec_md ? MD_LOAD : 4'd0;
                end
            end
            if (state == EXEC) begin
                if (capture) begin
                    out_result  <= sel_result;
                    out_illegal <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural external ALU
module tb_alu_issue;

    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_imm;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_r1, alu_r2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        ill;
    } exp_t;
    exp_t sb[$];

    alu_issue #(.MD_CYCLES(MD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .funct7(funct7), .is_imm(is_imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r1(alu_r1), .alu_r2(alu_r2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic [63:0] prod;
    always_comb begin
        prod   = {32'd0, alu_a} * {32'd0, alu_b};
        alu_r1 = 32'd0;
        alu_r2 = 32'd0;
        case (alu_op)
            4'h0: alu_r1 = alu_a << alu_b[4:0];
            4'h1: alu_r1 = $signed(alu_a) >>> alu_b[4:0];
            4'h2: alu_r1 = alu_a >> alu_b[4:0];
            4'h3: begin alu_r1 = prod[31:0]; alu_r2 = prod[63:32]; end
            4'h4: begin
                if (alu_b == 32'd0) begin
                    alu_r1 = 32'hDEAD_BEEF;
                    alu_r2 = 32'hDEAD_BEEF;
                end else begin
                    alu_r1 = alu_a / alu_b;
                    alu_r2 = alu_a % alu_b;
                end
            end
            4'h5: alu_r1 = alu_a + alu_b;
            4'h6: alu_r1 = alu_a - alu_b;
            4'h7: alu_r1 = alu_a & alu_b;
            4'h8: alu_r1 = alu_a | alu_b;
            4'h9: alu_r1 = alu_a ^ alu_b;
            4'hA: alu_r1 = ~(alu_a | alu_b);
            4'hB: alu_r1 = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'hC: alu_r1 = {31'd0, alu_a < alu_b};
            default: alu_r1 = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res", out_result, e.res);
                check("ill", {31'd0, out_illegal}, {31'd0, e.ill});
            end
        end
    end

    // RV32IM reference: returns {illegal, result}
    function automatic logic [32:0] ref_calc(input logic [2:0] f3, input logic [6:0] f7,
                                             input logic im, input logic [31:0] a,
                                             input logic [31:0] r2, input logic [31:0] iv);
        logic [31:0] b;
        logic [63:0] p;
        b = im ? iv : r2;
        p = {32'd0, a} * {32'd0, b};
        if (f7 == 7'b0000001) begin
            if (im) return {1'b1, 32'd0};
            case (f3)
                3'b000: return {1'b0, p[31:0]};
                3'b011: return {1'b0, p[63:32]};
                3'b101: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
                3'b111: return {1'b0, (b == 0) ? a : a % b};
                default: return {1'b1, 32'd0};
            endcase
        end
        case (f3)
            3'b000: return {1'b0, (f7[5] && !im) ? a - b : a + b};
            3'b001: return {1'b0, a << b[4:0]};
            3'b010: return {1'b0, 31'd0, $signed(a) < $signed(b)};
            3'b011: return {1'b0, 31'd0, a < b};
            3'b100: return {1'b0, a ^ b};
            3'b101: return {1'b0, f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0]};
            3'b110: return {1'b0, a | b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic im,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv,
                        input logic [31:0] exp_res, input logic exp_ill,
                        input int exp_lat, input int exp_op);
        int n;
        logic [31:0] a_before;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("rdy_timeout", {31'd0, in_ready}, 1);
        a_before = alu_a;
        funct3 = f3; funct7 = f7; is_imm = im;
        rs1_val = a; rs2_val = b; imm = iv;
        in_valid = 1'b1;
        e.res = exp_res; e.ill = exp_ill;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (exp_op >= 0) check("op", {28'd0, alu_op}, exp_op);
        if (exp_ill) check("keep_a", alu_a, a_before);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("lat", n + 1, exp_lat);
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_ref(input logic [2:0] f3, input logic [6:0] f7, input logic im,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv);
        logic [32:0] r;
        int lat;
        r = ref_calc(f3, f7, im, a, b, iv);
        lat = r[32] ? 1 : ((f7 == 7'b0000001) ? 1 + MD : 2);
        send(f3, f7, im, a, b, iv, r[31:0], r[32], lat, -1);
    endtask

    initial begin
        logic [31:0] held;
        logic [6:0]  f7;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = 3'd0; funct7 = 7'd0; is_imm = 1'b0;
        rs1_val = 32'd0; rs2_val = 32'd0; imm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_alu_op", {28'd0, alu_op}, 5);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_illegal", {31'd0, out_illegal}, 0);
        rst = 1'b0;

        send(3'b000, 7'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd4, 1'b0, 2, 5);
        send(3'b101, 7'b0100000, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000, 1'b0, 2, 1);
        send(3'b011, 7'b0000001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 1'b0, 1 + MD, 3);
        send(3'b000, 7'b0000001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0000_0001, 1'b0, 1 + MD, 3);
        send(3'b101, 7'b0000001, 1'b0, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1 + MD, 4);
        send(3'b111, 7'b0000001, 1'b0, 32'd7, 32'd0, 32'd0, 32'd7, 1'b0, 1 + MD, 4);
        send(3'b100, 7'b0000001, 1'b0, 32'd9, 32'd3, 32'd0, 32'd0, 1'b1, 1, -1);
        send(3'b000, 7'b0100000, 1'b0, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, 1'b0, 2, 6);
        send(3'b000, 7'b0000001, 1'b1, 32'd2, 32'd0, 32'd3, 32'd0, 1'b1, 1, -1);
        send(3'b111, 7'b0000001, 1'b0, 32'd100, 32'd7, 32'd0, 32'd2, 1'b0, 1 + MD, 4);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: f7 = 7'b0000000;
                1: f7 = 7'b0100000;
                default: f7 = 7'b0000001;
            endcase
            send_ref(3'($urandom_range(0, 7)), f7, 1'($urandom_range(0, 1)), $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom);
        end

        out_ready = 1'b0;
        send(3'b000, 7'd0, 1'b0, 32'd10, 32'd20, 32'd0, 32'd30, 1'b0, 2, 5);
        held = out_result;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 1);
            funct3 = 3'($urandom_range(0, 7));
            rs1_val = $urandom;
            @(posedge clk); #1;
            check("bp_valid", {31'd0, out_valid}, 1);
            check("bp_result", out_result, held);
            check("bp_in_ready", {31'd0, in_ready}, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {31'd0, in_ready}, 1);

        funct3 = 3'b000; funct7 = 7'b0000001; is_imm = 1'b0;
        rs1_val = 32'd3; rs2_val = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rmul_valid", {31'd0, out_valid}, 0);
        check("rmul_in_ready", {31'd0, in_ready}, 1);
        check("rmul_alu_op", {28'd0, alu_op}, 5);
        repeat (6) begin
            @(posedge clk); #1;
            check("rmul_quiet", {31'd0, out_valid}, 0);
        end

        funct3 = 3'b000; funct7 = 7'd0; rs1_val = 32'd11; rs2_val = 32'd22;
        in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0;
        check("rprio_in_ready", {31'd0, in_ready}, 1);
        check("rprio_alu_a", alu_a, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("rprio_quiet", {31'd0, out_valid}, 0);
        end

        send(3'b110, 7'd0, 1'b1, 32'hF0F0_0000, 32'd0, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 2, 8);
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter MD_CYCLES, default 4, cycles the multiply/divide result is held in EXEC before capture (legal 1..15).
REQ-002 clk  in  1  rising-edge clock; sole clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  request present; in_ready  out  1  request accepted when both high.
REQ-005 funct3  in  3, funct7  in  7  RV32IM R/I-type fields; is_imm  in  1  second operand is imm.
REQ-006 rs1_val, rs2_val, imm  in  32 each  operand values.
REQ-007 alu_a, alu_b  out  32  ALU operands; alu_op  out  4  ALU op code.
REQ-008 alu_r1, alu_r2  in  32 each  ALU result1/result2 (combinational from alu_a/alu_b/alu_op).
REQ-009 out_valid  out  1, out_ready  in  1  result handshake; out_result  out  32; out_illegal  out  1.

Function
REQ-010 ALU op map SHALL be: 0 SLL, 1 SRA, 2 SRL, 3 MUL ({r2,r1}=unsigned 64-bit product), 4 DIV (r1 quotient, r2 remainder, unsigned), 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, A NOR, B SLT, C SLTU.
REQ-011 Base decode (funct7 != 0000001): funct3 000 ADD, or SUB when funct7[5]=1 and is_imm=0; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5]=1; 110 OR; 111 AND.
REQ-012 M decode (funct7 = 0000001, is_imm=0): 000 MUL->op 3 select r1; 011 MULHU->op 3 select r2; 101 DIVU->op 4 select r1; 111 REMU->op 4 select r2; any other funct3, or funct7=0000001 with is_imm=1, is illegal.
REQ-013 On accept, alu_a<=rs1_val, alu_b<=(is_imm ? imm : rs2_val), alu_op, result select and md flag SHALL be registered; alu_a/alu_b/alu_op are driven only from these registers.
REQ-014 FSM states IDLE, EXEC, HOLD; in_ready = (state==IDLE).
REQ-015 IDLE: accept -> EXEC; illegal accept -> HOLD directly, out_result=0, out_illegal=1, operand registers unchanged.
REQ-016 EXEC, non-M op: capture selected ALU result into out_result on first EXEC cycle, -> HOLD.
REQ-017 EXEC, M op: 4-bit counter loads MD_CYCLES-1 on entry, decrements each cycle; capture and -> HOLD when counter is 0.
REQ-018 Divide by zero (alu_b=0): DIVU SHALL yield 0xFFFFFFFF, REMU SHALL yield alu_a, regardless of alu_r1/alu_r2.
REQ-019 HOLD: out_valid=1, out_result/out_illegal stable; out_ready=1 -> IDLE next cycle; else remain.
REQ-020 Latency: accept at edge t -> out_valid from edge t+2 (non-M) or t+1+MD_CYCLES (M); illegal -> t+1.
REQ-021 No new request is accepted in EXEC or HOLD, even when out_ready is high in HOLD; minimum non-M issue interval 3 cycles.
REQ-022 in_valid and operand fields are ignored outside IDLE; alu_r1/alu_r2 ignored outside EXEC.
REQ-023 out_illegal SHALL clear on the next legal capture.

Reset
REQ-024 rst high at a rising edge SHALL force state IDLE, counter 0, alu_a=0, alu_b=0, alu_op=4'b0101, out_result=0, out_valid=0, out_illegal=0, in_ready=1 next cycle.
REQ-025 rst SHALL override any in-progress EXEC/HOLD; the pending result is discarded and never presented.
REQ-026 rst has priority over a simultaneous accept; that request is not taken.

Verification
REQ-027 ADD: rs1=5, rs2=0xFFFFFFFF, funct3=000, funct7=0 -> alu_op=5, out_result=4 with out_valid at t+2.
REQ-028 SRAI: rs1=0x80000000, imm=4, is_imm=1, funct3=101, funct7=0100000 -> alu_op=1, out_result=0xF8000000.
REQ-029 MULHU, MD_CYCLES=4: rs1=rs2=0xFFFFFFFF -> out_result=0xFFFFFFFE at t+5; MUL same operands -> 0x00000001.
REQ-030 DIVU/REMU by zero: rs1=7, rs2=0 -> 0xFFFFFFFF and 7; funct3=100 with M funct7 -> out_illegal=1, out_result=0 at t+1.
REQ-031 Backpressure: out_ready held low 10 cycles -> out_valid/out_result stable, in_ready=0 throughout; in_valid pulses ignored.
REQ-032 Reset mid-MUL (third EXEC cycle) -> next cycle out_valid=0, in_ready=1, alu_op=5, no result presented.
